sprite_plotter: RTL
===================

Name: sprite_plotter

Overview:
- Pixel-level drawing stage that sits directly downstream of the object-motion datapath.
- Takes one object origin (x, y) plus an erase/draw request and walks the WIDTH x HEIGHT bounding box one pixel per clock.
- Emits x/y/colour/writeEn to the 160x120 VGA adapter.
- Erase paints the whole box in background colour. Draw paints only the pixels set in a sprite mask.
- Clips pixels that fall off-screen.

Parameters:
- WIDTH, 8, sprite width in pixels (1..16).
- HEIGHT, 8, sprite height in pixels (1..16).
- DRAW_COLOUR, 3'b111, colour for mask-set pixels in draw mode.
- BG_COLOUR, 3'b000, colour for every pixel in erase mode.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- erase  in  1  mode captured with start: 1 = erase box, 0 = draw sprite.
- x_in  in  8  left column of object (0..255; values above 159 are clipped).
- y_in  in  6  top row of object, zero-extended to 7 bits.
- plot_x  out  8  pixel column to VGA adapter.
- plot_y  out  7  pixel row to VGA adapter.
- colour  out  3  pixel colour.
- writeEn  out  1  VGA write strobe.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (asynchronous, resetn=0), effective immediately including mid-request:
  - state=IDLE, all counters 0, latched x0/y0/mode 0.
  - plot_x=0, plot_y=0, colour=0, writeEn=0, busy=0, done=0.
  - No partial-request resume after reset is released.
- States: IDLE, DRAW, DONE.
- IDLE:
  - On a clock edge with start=1, latch x0=x_in, y0={1'b0,y_in}, mode=erase; cx=0, cy=0; go to DRAW.
  - With start=0, stay in IDLE; writeEn=0, busy=0.
- DRAW, one pixel per cycle:
  - All outputs are registered. The first pixel (cx=0, cy=0) is presented in the cycle after start is accepted.
  - px = x0 + cx, computed 9 bits wide; py = y0 + cy, computed 8 bits wide.
  - plot_x = px[7:0], plot_y = py[6:0].
  - Visible pixel: px <= 159 and py <= 119.
  - Erase mode: writeEn = visible; colour = BG_COLOUR.
  - Draw mode: writeEn = visible and mask(cx,cy); colour = DRAW_COLOUR.
  - Draw mode, transparent pixel: writeEn=0 and colour=BG_COLOUR.
  - Counter advance: cx increments; at cx=WIDTH-1, cx wraps to 0 and cy increments. A clipped or transparent pixel still takes its cycle.
  - After the pixel with cx=WIDTH-1, cy=HEIGHT-1, go to DONE.
  - busy=1 throughout DRAW.
- DONE (exactly one cycle): done=1, busy=0, writeEn=0; then IDLE.
- Timing: exactly WIDTH*HEIGHT DRAW cycles per request. Start-accept edge to done-high cycle = WIDTH*HEIGHT+1 cycles.
- Back-to-back: start asserted in the DONE cycle is ignored. The next request is accepted from IDLE, one cycle later.
- start during DRAW or DONE is ignored; x_in, y_in and erase may change freely after acceptance.
- Wrap-around: origin near the right/bottom edge never wraps onto column 0 / row 0. The clipping comparisons use the full-width sums.

Decomposition:
- Shared package (vga_pkg):
  - SCREEN_W=160, SCREEN_H=120, COLOUR_W=3.
  - Plotter state encoding: IDLE=2'd0, DRAW=2'd1, DONE=2'd2.
- Sub-module sprite_mask_rom:
  - Combinational lookup of mask bit from (cx[3:0], cy[3:0]).
  - Default pattern is a filled box with the four corner pixels cleared.
  - Replaceable without touching the FSM.

Test Plan:
- Reset then idle 10 cycles with start=0 -> writeEn, busy, done stay 0; outputs 0.
- Erase, start with x_in=10, y_in=20 -> 64 consecutive writeEn cycles with colour=000, covering plot_x 10..17 and plot_y 20..27 in row-major order; done pulses once at cycle 65 after acceptance.
- Draw, start with x_in=40, y_in=5 -> 60 writes with colour=111; corner pixels (40,5), (47,5), (40,12), (47,12) are not written; done at cycle 65.
- Draw, start with x_in=156, y_in=63 -> only columns 156..159 are written (rows 63..70, minus corner pixels); no write to columns 0..3; still 64 DRAW cycles.
- Start, then pulse start again with new x_in at cycles 5 and 64, then pulse start during the DONE cycle -> none accepted; plot_x stays in the original range; the next start accepted the cycle after DONE.
- Assert resetn=0 at pixel 30 of a request -> writeEn, busy and done drop to 0 immediately with no clock edge needed; after release, IDLE and a fresh request completes normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and plotter state encoding for the 160x120 VGA drawing path.
package vga_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned COLOUR_W = 3;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDraw = 2'd1,
      StDone = 2'd2
   } plot_state_e;

   // Operands are the full-width sums so an origin near the edge never wraps on screen.
   function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
      return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
   endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between the motion datapath, the plotter and the VGA adapter.
interface sprite_plotter_if;
   import vga_pkg::*;

   logic                start;
   logic                erase;
   logic [7:0]          x_in;
   logic [5:0]          y_in;
   logic [7:0]          plot_x;
   logic [6:0]          plot_y;
   logic [COLOUR_W-1:0] colour;
   logic                writeEn;
   logic                busy;
   logic                done;

   modport master (
      output start, erase, x_in, y_in,
      input  plot_x, plot_y, colour, writeEn, busy, done
   );

   modport slave (
      input  start, erase, x_in, y_in,
      output plot_x, plot_y, colour, writeEn, busy, done
   );

endinterface

// File: rtl/sprite_mask_rom.sv
// Combinational sprite mask: a filled WIDTH x HEIGHT box with the four corners cleared.
module sprite_mask_rom #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned HEIGHT = 8
) (
   input  logic [3:0] cx,
   input  logic [3:0] cy,
   output logic       mask
);

   logic in_box;
   logic col_edge;
   logic row_edge;

   always_comb begin
      in_box   = ({1'b0, cx} < 5'(WIDTH)) && ({1'b0, cy} < 5'(HEIGHT));
      col_edge = (cx == 4'd0) || (cx == 4'(WIDTH - 1));
      row_edge = (cy == 4'd0) || (cy == 4'(HEIGHT - 1));
      mask     = in_box && !(col_edge && row_edge);
   end

endmodule

// File: rtl/sprite_plotter.sv
// Walks a WIDTH x HEIGHT box one pixel per clock, emitting clipped erase/draw writes
// to the VGA adapter. All outputs are registered from next-state values.
module sprite_plotter
   import vga_pkg::*;
#(
   parameter int unsigned         WIDTH       = 8,
   parameter int unsigned         HEIGHT      = 8,
   parameter logic [COLOUR_W-1:0] DRAW_COLOUR = 3'b111,
   parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000
) (
   input logic              clk,
   input logic              resetn,
   sprite_plotter_if.slave  bus
);

   localparam logic [3:0] LastX = 4'(WIDTH - 1);
   localparam logic [3:0] LastY = 4'(HEIGHT - 1);

   plot_state_e state_q, state_d;
   logic [3:0]  cx_q, cx_d;
   logic [3:0]  cy_q, cy_d;
   logic [7:0]  x0_q, x0_d;
   logic [6:0]  y0_q, y0_d;
   logic        mode_q, mode_d;

   logic [7:0]          plot_x_q, plot_x_d;
   logic [6:0]          plot_y_q, plot_y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                write_q, write_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [8:0] px;
   logic [7:0] py;
   logic       visible;
   logic       mask;

   sprite_mask_rom #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_mask (
      .cx   (cx_d),
      .cy   (cy_d),
      .mask (mask)
   );

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      mode_d  = mode_q;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               x0_d    = bus.x_in;
               y0_d    = {1'b0, bus.y_in};
               mode_d  = bus.erase;
               cx_d    = 4'd0;
               cy_d    = 4'd0;
               state_d = StDraw;
            end
         end
         StDraw: begin
            if (cx_q == LastX) begin
               cx_d = 4'd0;
               if (cy_q == LastY) begin
                  cy_d    = 4'd0;
                  state_d = StDone;
               end else begin
                  cy_d = cy_q + 4'd1;
               end
            end else begin
               cx_d = cx_q + 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output registers load the pixel that the next state will present.
   always_comb begin
      px      = {1'b0, x0_d} + 9'(cx_d);
      py      = {1'b0, y0_d} + 8'(cy_d);
      visible = on_screen(px, py);

      plot_x_d = 8'd0;
      plot_y_d = 7'd0;
      colour_d = '0;
      write_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      if (state_d == StDraw) begin
         plot_x_d = px[7:0];
         plot_y_d = py[6:0];
         busy_d   = 1'b1;
         if (mode_d) begin
            write_d  = visible;
            colour_d = BG_COLOUR;
         end else begin
            write_d  = visible && mask;
            colour_d = mask ? DRAW_COLOUR : BG_COLOUR;
         end
      end else if (state_d == StDone) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         cx_q     <= 4'd0;
         cy_q     <= 4'd0;
         x0_q     <= 8'd0;
         y0_q     <= 7'd0;
         mode_q   <= 1'b0;
         plot_x_q <= 8'd0;
         plot_y_q <= 7'd0;
         colour_q <= '0;
         write_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         mode_q   <= mode_d;
         plot_x_q <= plot_x_d;
         plot_y_q <= plot_y_d;
         colour_q <= colour_d;
         write_q  <= write_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.plot_x  = plot_x_q;
   assign bus.plot_y  = plot_y_q;
   assign bus.colour  = colour_q;
   assign bus.writeEn = write_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
